// File: rtl/fir_mavg_lpf.sv
// Moving-average low-pass filter with window N = 2^mode and a WARM/RUN warm-up gate.
// Define FIR_MAVG_ROUND_EN to round half-up instead of truncating the average.
module fir_mavg_lpf #(
  parameter int DW     = 8,
  parameter int MODE_W = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [MODE_W-1:0] mode,
  input  logic              din_valid,
  input  logic [DW-1:0]     din,
  output logic              dout_valid,
  output logic [DW-1:0]     dout
);

  localparam int MAXMODE = (1 << MODE_W) - 1;
  localparam int NMAX    = 1 << MAXMODE;
  localparam int ACC_W   = DW + MAXMODE;
  localparam int IDX_W   = MAXMODE;
  localparam int CNT_W   = MAXMODE + 1;

  localparam logic [0:0] ST_WARM = 1'b0;
  localparam logic [0:0] ST_RUN  = 1'b1;

  logic [MODE_W-1:0] mode_q, mode_d;
  logic [0:0]        state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [ACC_W-1:0]  acc_q, acc_d;
  logic [DW-1:0]     tap_q [NMAX];
  logic [DW-1:0]     tap_d [NMAX];
  logic [DW-1:0]     dout_q, dout_d;
  logic              dout_valid_q, dout_valid_d;

  logic              mode_chg;
  logic [CNT_W-1:0]  win_len;
  logic [IDX_W-1:0]  oldest_idx;
  logic [DW-1:0]     oldest;
  logic [ACC_W-1:0]  acc_sum;
  logic [ACC_W-1:0]  half;
  logic [ACC_W-1:0]  acc_rnd;
  logic [DW-1:0]     avg;
  logic [CNT_W-1:0]  cnt_inc;
  logic              win_full;

  // Datapath: the sample leaving the window is tap[N-1] before the shift.
  always_comb begin
    mode_chg   = (mode != mode_q);
    win_len    = CNT_W'(1) << mode_q;
    oldest_idx = IDX_W'(win_len - CNT_W'(1));
    oldest     = tap_q[oldest_idx];
    acc_sum    = acc_q + ACC_W'(din) - ACC_W'(oldest);
`ifdef FIR_MAVG_ROUND_EN
    half       = ACC_W'(win_len >> 1);
`else
    half       = '0;
`endif
    acc_rnd    = acc_sum + half;
    avg        = DW'(acc_rnd >> mode_q);
    cnt_inc    = cnt_q + CNT_W'(1);
    win_full   = (cnt_inc == win_len);
  end

  // NOTE: every _d gets its _q value first so no path leaves it unassigned (no latch).
  always_comb begin
    mode_d       = mode_q;
    state_d      = state_q;
    cnt_d        = cnt_q;
    acc_d        = acc_q;
    tap_d        = tap_q;
    dout_d       = dout_q;
    dout_valid_d = 1'b0;

    if (mode_chg) begin
      // The strobe on a change cycle is dropped: its sample belongs to no window.
      mode_d  = mode;
      state_d = ST_WARM;
      cnt_d   = '0;
      acc_d   = '0;
      for (int i = 0; i < NMAX; i++) tap_d[i] = '0;
    end else if (din_valid) begin
      acc_d    = acc_sum;
      tap_d[0] = din;
      for (int i = 1; i < NMAX; i++) tap_d[i] = tap_q[i-1];

      if (state_q == ST_RUN) begin
        dout_d       = avg;
        dout_valid_d = 1'b1;
      end else begin
        // Partial-window averages are never published; dout keeps the last valid result.
        cnt_d = cnt_inc;
        if (win_full) begin
          state_d      = ST_RUN;
          dout_d       = avg;
          dout_valid_d = 1'b1;
        end
      end
    end
  end

  // NOTE: sequential state uses <= only so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      mode_q       <= mode;
      state_q      <= ST_WARM;
      cnt_q        <= '0;
      acc_q        <= '0;
      // NOTE: the delay line is cleared on reset because stale taps would corrupt the running sum.
      for (int i = 0; i < NMAX; i++) tap_q[i] <= '0;
      dout_q       <= '0;
      dout_valid_q <= 1'b0;
    end else begin
      mode_q       <= mode_d;
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      acc_q        <= acc_d;
      for (int i = 0; i < NMAX; i++) tap_q[i] <= tap_d[i];
      dout_q       <= dout_d;
      dout_valid_q <= dout_valid_d;
    end
  end

  assign dout       = dout_q;
  assign dout_valid = dout_valid_q;

endmodule

// File: tb/tb_fir_mavg_lpf.sv
// Directed self-checking bench for fir_mavg_lpf: reset, ramp, full scale,
// mode change, valid gaps and reset in mid-window.
module tb_fir_mavg_lpf;

  localparam int DW     = 8;
  localparam int MODE_W = 2;

`ifdef FIR_MAVG_ROUND_EN
  localparam logic [DW-1:0] RAMP4 = 8'd8;
  localparam logic [DW-1:0] RAMP5 = 8'd13;
`else
  localparam logic [DW-1:0] RAMP4 = 8'd7;
  localparam logic [DW-1:0] RAMP5 = 8'd12;
`endif

  logic              clk = 1'b0;
  logic              rst_n;
  logic [MODE_W-1:0] mode;
  logic              din_valid;
  logic [DW-1:0]     din;
  logic              dout_valid;
  logic [DW-1:0]     dout;

  int vectors     = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  fir_mavg_lpf #(.DW(DW), .MODE_W(MODE_W)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .mode       (mode),
    .din_valid  (din_valid),
    .din        (din),
    .dout_valid (dout_valid),
    .dout       (dout)
  );

  // Drive one cycle's inputs, then sample just after the rising edge.
  task automatic step(input logic v, input logic [DW-1:0] d);
    din_valid = v;
    din       = d;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic exp_v, input logic [DW-1:0] exp_d);
    vectors++;
    assert (dout_valid === exp_v) else begin
      miscompares++;
      $error("FAIL %s dout_valid observed=%0b expected=%0b", tag, dout_valid, exp_v);
    end
    vectors++;
    assert (dout === exp_d) else begin
      miscompares++;
      $error("FAIL %s dout observed=%0d expected=%0d", tag, dout, exp_d);
    end
  endtask

  initial begin
    rst_n     = 1'b0;
    mode      = 2'd2;
    din_valid = 1'b0;
    din       = '0;

    // Reset for two cycles with mode 2; release with mode unchanged.
    step(1'b0, 8'd0);
    step(1'b0, 8'd0);
    chk("reset", 1'b0, 8'd0);
    rst_n = 1'b1;

    // Mode 2 ramp; the first sample after release must be accepted.
    step(1'b1, 8'd0);  chk("ramp_s1", 1'b0, 8'd0);
    step(1'b1, 8'd5);  chk("ramp_s2", 1'b0, 8'd0);
    step(1'b1, 8'd10); chk("ramp_s3", 1'b0, 8'd0);
    step(1'b1, 8'd15); chk("ramp_s4", 1'b1, RAMP4);
    step(1'b1, 8'd20); chk("ramp_s5", 1'b1, RAMP5);
    step(1'b0, 8'd0);  chk("ramp_idle", 1'b0, RAMP5);

    // Mode 3 full scale: change cycle discarded, then 8 samples to fill.
    mode = 2'd3;
    step(1'b1, 8'd255); chk("fs_change", 1'b0, RAMP5);
    for (int i = 0; i < 7; i++) begin
      step(1'b1, 8'd255); chk("fs_warm", 1'b0, RAMP5);
    end
    step(1'b1, 8'd255); chk("fs_8th", 1'b1, 8'd255);
    step(1'b1, 8'd255); chk("fs_run1", 1'b1, 8'd255);
    step(1'b1, 8'd255); chk("fs_run2", 1'b1, 8'd255);

    // Mode change 3 -> 0 mid-stream with din_valid held high.
    mode = 2'd0;
    step(1'b1, 8'd99); chk("m0_change", 1'b0, 8'd255);
    step(1'b1, 8'd40); chk("m0_first", 1'b1, 8'd40);
    step(1'b1, 8'd41); chk("m0_next", 1'b1, 8'd41);

    // Mode 1 with a three-cycle valid gap between the two window samples.
    mode = 2'd1;
    step(1'b1, 8'd77); chk("m1_change", 1'b0, 8'd41);
    step(1'b1, 8'd10); chk("m1_first", 1'b0, 8'd41);
    for (int i = 0; i < 3; i++) begin
      step(1'b0, 8'd0); chk("gap_idle", 1'b0, 8'd41);
    end
    step(1'b1, 8'd30); chk("gap_30", 1'b1, 8'd20);

    // Mode 2, two samples of 100, then reset discards them.
    mode = 2'd2;
    step(1'b0, 8'd0);   chk("rm_change", 1'b0, 8'd20);
    step(1'b1, 8'd100);
    step(1'b1, 8'd100); chk("rm_partial", 1'b0, 8'd20);
    rst_n = 1'b0;
    step(1'b0, 8'd0);   chk("rm_reset", 1'b0, 8'd0);
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step(1'b1, 8'd8); chk("rm_warm", 1'b0, 8'd0);
    end
    step(1'b1, 8'd8); chk("rm_4th", 1'b1, 8'd8);
    step(1'b0, 8'd0); chk("rm_idle", 1'b0, 8'd8);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/fir_mavg_lpf.md
FIR_MAVG_LPF -- requirements
Module: fir_mavg_lpf

Interface
REQ-001 SHALL have parameter DW, default 8, meaning input/output sample width (unsigned).
REQ-002 SHALL have parameter MODE_W, default 2, meaning mode width.
- Window length N = 2^mode.
- Maximum window NMAX = 2^(2^MODE_W - 1), which is 8 at the default.
REQ-003 SHALL have port clk, input, 1, sole clock; all logic on rising edge.
REQ-004 SHALL have port rst_n, input, 1, reset, synchronous and active-low.
REQ-005 SHALL have port mode, input, MODE_W, window select; 0 means bypass (N=1).
REQ-006 SHALL have port din_valid, input, 1, sample strobe.
REQ-007 SHALL have port din, input, DW, sample.
REQ-008 SHALL have port dout_valid, output, 1, one-cycle strobe per filtered sample.
REQ-009 SHALL have port dout, output, DW, filtered sample, registered.

Function
REQ-010 SHALL implement a moving-average low-pass filter: dout = (sum of the last N accepted samples) >> mode.
REQ-011 SHALL keep a delay line of NMAX words and a running accumulator of width DW+2^MODE_W-1.
- Update per accepted sample: acc <= acc + din - tap[N-1].
- Accumulator never overflows.
REQ-012 SHALL accept a sample only on a clk edge where din_valid=1 and no mode change is detected.
REQ-013 SHALL present dout and dout_valid exactly 1 cycle after the accepted sample (latency 1).
REQ-014 SHALL hold dout at its last value and drive dout_valid=0 on cycles with no accepted sample.
REQ-015 SHALL register mode into mode_q; a mode change is detected whenever mode != mode_q at a clk edge.
REQ-016 SHALL, on a detected mode change:
- clear the delay line, accumulator and warm-up counter to 0;
- load mode_q;
- enter WARM;
- discard din in that cycle even if din_valid=1.
REQ-017 SHALL use the state machine WARM -> RUN.
- WARM: samples are accepted, but dout_valid stays 0 until the Nth accepted sample since the clear.
- WARM -> RUN: transition on the Nth accepted sample; that sample's result asserts dout_valid=1.
- RUN: every accepted sample gives dout_valid=1.
- RUN -> WARM: only on a mode change or reset.
REQ-018 SHALL, in mode 0, make the first accepted sample after a clear valid immediately, with dout = din (pure 1-cycle register).
REQ-019 SHALL continue operating correctly with din_valid gaps.
- Idle cycles do not advance the delay line, the accumulator or the warm-up counter.

Reset
REQ-020 SHALL, when rst_n=0 at a clk edge:
- set dout=0 and dout_valid=0;
- clear the delay line, accumulator and warm-up counter;
- set state=WARM;
- load mode_q <= mode, so no spurious flush follows reset.
REQ-021 SHALL give reset priority over sample acceptance and mode-change handling.
- Reset asserted mid-window discards all partial history.

Configuration
REQ-022 SHALL support macro FIR_MAVG_ROUND_EN.
- Defined: dout = (acc + (N>>1)) >> mode, i.e. round-half-up. In mode 0 the added term is 0.
- Undefined: dout = acc >> mode, i.e. truncation.
- Never saturates in either case: the maximum result is 2^DW-1.

Verification
REQ-023 SHALL pass reset: rst_n=0 for 2 cycles with mode=2 -> dout=0, dout_valid=0, and no flush after release.
REQ-024 SHALL pass the mode 2 ramp: din 0,5,10,15,20 on consecutive valid cycles.
- dout_valid=0 for the first 3 samples.
- Truncation: 4th sample -> 7, 5th sample -> 12.
- FIR_MAVG_ROUND_EN: 4th sample -> 8, 5th sample -> 13.
REQ-025 SHALL pass the mode 3 full scale: din=255 continuously.
- The first valid output appears on the 8th sample's result cycle, value 255.
- dout_valid stays 1 thereafter.
REQ-026 SHALL pass a mode change mid-stream, 3 -> 0, with din_valid=1.
- The change cycle's sample is discarded.
- The next sample, 40, gives dout=40 with dout_valid=1 one cycle later.
REQ-027 SHALL pass a valid gap: mode 1, samples 10,(gap of 3 idle cycles),30.
- Idle cycles give dout_valid=0 with dout held.
- Sample 30 gives dout=20.
REQ-028 SHALL pass reset mid-window: mode 2 after 2 samples of 100, apply rst_n=0 for 1 cycle, then 4 samples of 8.
- The first valid dout is 8; the old 100s do not contribute.
